// File: rtl/piso_pkg.sv
// Shared types for the PISO serializer controller.
//   state_t   : sequencer states (idle, shifting a frame, inter-frame gap)
//   SEL_LOAD  : shifter select value for a parallel load
//   SEL_SHIFT : shifter select value for a one-bit shift
package piso_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic SEL_LOAD  = 1'b0;
  localparam logic SEL_SHIFT = 1'b1;

endpackage

// File: rtl/piso_shift_reg.sv
// WIDTH-bit parallel-in/serial-out shift register.
//   CLK   : clock, rising edge
//   RST_N : asynchronous active-low clear
//   LOAD  : capture D (has priority over SHIFT)
//   SHIFT : advance one bit toward the serial output, zero fill
//   D     : parallel load word
//   Q     : current serial bit (D[WIDTH-1] first when MSB_FIRST, else D[0])
// Holds its contents when neither LOAD nor SHIFT is asserted.
module piso_shift_reg #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             LOAD,
  input  logic             SHIFT,
  input  logic [WIDTH-1:0] D,
  output logic             Q
);

  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    if (MSB_FIRST) shifted = {r[WIDTH-2:0], 1'b0};
    else           shifted = {1'b0, r[WIDTH-1:1]};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)      r <= '0;
    else if (LOAD)   r <= D;
    else if (SHIFT)  r <= shifted;
  end

  assign Q = MSB_FIRST ? r[WIDTH-1] : r[0];

endmodule

// File: rtl/piso_serializer_ctrl.sv
// Sequencer for the parallel-in/serial-out datapath.
//   CLK       : clock, rising edge
//   RST_N     : asynchronous active-low reset
//   IN_DATA   : parallel word
//   IN_VALID  : IN_DATA valid
//   IN_READY  : one-word holding buffer is empty
//   EN        : bit-time enable; low freezes pacing
//   SER_OUT   : serial data
//   SER_VALID : SER_OUT carries a frame bit
//   SER_FIRST : first bit-time of a frame
//   SER_LAST  : last bit-time of a frame
//   BUSY      : sequencer active or buffer full
module piso_serializer_ctrl
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DIV       = 1,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             EN,
  output logic             SER_OUT,
  output logic             SER_VALID,
  output logic             SER_FIRST,
  output logic             SER_LAST,
  output logic             BUSY
);

  localparam int BW      = $clog2(WIDTH);
  localparam int CW      = $clog2(DIV*GAP + DIV + 1);
  localparam int GAP_CYC = (GAP > 0) ? GAP*DIV : 1;

  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH-1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV-1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC-1);

  state_t           state, state_n;
  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic [CW-1:0]    div_cnt, div_n;
  logic [BW-1:0]    bit_cnt, bit_n;
  logic [CW-1:0]    gap_cnt, gap_n;

  logic sr_en, sr_sel, sr_q;
  logic drain, try_reload;

  // Idle, end of frame (no gap) and end of gap all share one
  // reload-or-idle decision, resolved after the case statement.
  always_comb begin
    state_n    = state;
    div_n      = div_cnt;
    bit_n      = bit_cnt;
    gap_n      = gap_cnt;
    sr_en      = 1'b0;
    sr_sel     = SEL_SHIFT;
    drain      = 1'b0;
    try_reload = 1'b0;

    unique case (state)
      S_IDLE: try_reload = 1'b1;

      S_SHIFT: begin
        if (EN) begin
          if (div_cnt == DIV_LAST) begin
            div_n  = '0;
            sr_en  = 1'b1;
            sr_sel = SEL_SHIFT;
            if (bit_cnt == BIT_LAST) begin
              bit_n = '0;
              if (GAP > 0) begin
                state_n = S_GAP;
                gap_n   = '0;
              end else begin
                try_reload = 1'b1;
              end
            end else begin
              bit_n = bit_cnt + 1'b1;
            end
          end else begin
            div_n = div_cnt + 1'b1;
          end
        end
      end

      S_GAP: begin
        if (EN) begin
          if (gap_cnt == GAP_LAST) begin
            gap_n      = '0;
            try_reload = 1'b1;
          end else begin
            gap_n = gap_cnt + 1'b1;
          end
        end
      end

      default: state_n = S_IDLE;
    endcase

    if (try_reload) begin
      if (hold_full) begin
        state_n = S_SHIFT;
        sr_en   = 1'b1;
        sr_sel  = SEL_LOAD;
        drain   = 1'b1;
        div_n   = '0;
        bit_n   = '0;
        gap_n   = '0;
      end else begin
        state_n = S_IDLE;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      hold_full <= 1'b0;
      hold_data <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      state   <= state_n;
      div_cnt <= div_n;
      bit_cnt <= bit_n;
      gap_cnt <= gap_n;
      // Accept only when empty, drain only when full: never both in one edge.
      if (drain) begin
        hold_full <= 1'b0;
      end else if (IN_VALID && !hold_full) begin
        hold_full <= 1'b1;
        hold_data <= IN_DATA;
      end
    end
  end

  piso_shift_reg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_sr (
    .CLK  (CLK),
    .RST_N(RST_N),
    .LOAD (sr_en && (sr_sel == SEL_LOAD)),
    .SHIFT(sr_en && (sr_sel == SEL_SHIFT)),
    .D    (hold_data),
    .Q    (sr_q)
  );

  assign IN_READY  = ~hold_full;
  assign SER_VALID = (state == S_SHIFT);
  assign SER_OUT   = SER_VALID & sr_q;
  assign SER_FIRST = SER_VALID && (bit_cnt == '0);
  assign SER_LAST  = SER_VALID && (bit_cnt == BIT_LAST);
  assign BUSY      = (state != S_IDLE) || hold_full;

endmodule

// File: tb/tb_piso_serializer_ctrl.sv
// Bench for piso_serializer_ctrl: four parameterisations share one input
// stream; a frame/slot-level model per instance predicts every output on
// every cycle, and directed sequences pin literal stream contents.
`timescale 1ns/1ps
module tb_piso_serializer_ctrl;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic [3:0] in_data  = '0;
  logic       in_valid = 1'b0;
  logic       en       = 1'b1;
  logic [3:0] rdy, bsy, sv, so, sf, sl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_serializer_ctrl #(.WIDTH(4), .DIV(1), .MSB_FIRST(1'b1), .GAP(0)) u0 (
    .CLK(clk), .RST_N(rst_n), .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(rdy[0]),
    .EN(en), .SER_OUT(so[0]), .SER_VALID(sv[0]), .SER_FIRST(sf[0]), .SER_LAST(sl[0]), .BUSY(bsy[0]));
  piso_serializer_ctrl #(.WIDTH(4), .DIV(3), .MSB_FIRST(1'b1), .GAP(0)) u1 (
    .CLK(clk), .RST_N(rst_n), .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(rdy[1]),
    .EN(en), .SER_OUT(so[1]), .SER_VALID(sv[1]), .SER_FIRST(sf[1]), .SER_LAST(sl[1]), .BUSY(bsy[1]));
  piso_serializer_ctrl #(.WIDTH(4), .DIV(1), .MSB_FIRST(1'b0), .GAP(2)) u2 (
    .CLK(clk), .RST_N(rst_n), .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(rdy[2]),
    .EN(en), .SER_OUT(so[2]), .SER_VALID(sv[2]), .SER_FIRST(sf[2]), .SER_LAST(sl[2]), .BUSY(bsy[2]));
  piso_serializer_ctrl #(.WIDTH(4), .DIV(2), .MSB_FIRST(1'b0), .GAP(1)) u3 (
    .CLK(clk), .RST_N(rst_n), .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(rdy[3]),
    .EN(en), .SER_OUT(so[3]), .SER_VALID(sv[3]), .SER_FIRST(sf[3]), .SER_LAST(sl[3]), .BUSY(bsy[3]));

  function automatic int cfg_div(input int i);
    case (i)
      1:       return 3;
      3:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic bit cfg_msb(input int i);
    return (i < 2);
  endfunction

  function automatic int cfg_gap(input int i);
    case (i)
      2:       return 2;
      3:       return 1;
      default: return 0;
    endcase
  endfunction

  // Model: a frame is a list of 4+GAP slots, each lasting DIV enabled cycles.
  bit         m_full [4];
  logic [3:0] m_data [4];
  bit         m_act  [4];
  int         m_pos  [4];
  int         m_cnt  [4];
  logic [3:0] m_frame[4];   // bit k = k-th bit on the line

  task automatic model_load(input int i);
    m_act[i]  = 1'b1;
    m_pos[i]  = 0;
    m_cnt[i]  = 0;
    m_full[i] = 1'b0;
    for (int k = 0; k < 4; k++)
      m_frame[i][k] = cfg_msb(i) ? m_data[i][3-k] : m_data[i][k];
  endtask

  task automatic model_step(input int i);
    bit acc;
    acc = in_valid && !m_full[i];
    if (!m_act[i]) begin
      if (m_full[i]) model_load(i);
    end else if (en) begin
      m_cnt[i]++;
      if (m_cnt[i] == cfg_div(i)) begin
        m_cnt[i] = 0;
        m_pos[i]++;
        if (m_pos[i] == 4 + cfg_gap(i)) begin
          m_act[i] = 1'b0;
          if (m_full[i]) model_load(i);
        end
      end
    end
    if (acc) begin
      m_full[i] = 1'b1;
      m_data[i] = in_data;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        m_full[i] = 1'b0; m_act[i] = 1'b0; m_pos[i] = 0; m_cnt[i] = 0;
      end else begin
        model_step(i);
      end
    end
  end

  task automatic chk(input int i, input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL inst%0d %s: got %b expected %b at %0t", i, nm, got, exp, $time);
    end
  endtask

  task automatic pin(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Observed-stream capture for the directed pins.
  logic [15:0] cap    [4];
  int          vcnt   [4];
  int          run    [4];
  int          maxrun [4];
  int          zrun   [4];
  int          lastgap[4];
  bit          seen   [4];

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      logic ev;
      logic eo;
      ev = m_act[i] && (m_pos[i] < 4);
      eo = ev ? m_frame[i][m_pos[i][1:0]] : 1'b0;
      chk(i, "IN_READY",  rdy[i], !m_full[i]);
      chk(i, "BUSY",      bsy[i], m_act[i] || m_full[i]);
      chk(i, "SER_VALID", sv[i],  ev);
      chk(i, "SER_OUT",   so[i],  eo);
      chk(i, "SER_FIRST", sf[i],  ev && (m_pos[i] == 0));
      chk(i, "SER_LAST",  sl[i],  ev && (m_pos[i] == 3));
      if (sv[i] === 1'b1) begin
        cap[i] = {cap[i][14:0], so[i]};
        vcnt[i]++;
        run[i]++;
        if (run[i] > maxrun[i]) maxrun[i] = run[i];
        if (seen[i] && zrun[i] > 0) lastgap[i] = zrun[i];
        zrun[i] = 0;
        seen[i] = 1'b1;
      end else begin
        run[i] = 0;
        zrun[i]++;
      end
    end
  end

  task automatic clear_cap();
    for (int i = 0; i < 4; i++) begin
      cap[i] = '0; vcnt[i] = 0; run[i] = 0; maxrun[i] = 0;
      zrun[i] = 0; lastgap[i] = 0; seen[i] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    clear_cap();
  endtask

  // Handshake paced by instance 0's ready.
  task automatic send_word(input logic [3:0] d);
    bit r;
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 200; k++) begin
      r = rdy[0];
      tick();
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    pin("send_accepted", int'(ok), 1);
  endtask

  task automatic wait_idle(input int limit);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      if (bsy == 4'b0000) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    pin("idle_reached", int'(ok), 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    clear_cap();
    #1;
    pin("reset_ready0", int'(rdy[0]), 1);
    pin("reset_busy",   int'(bsy), 0);
    pin("reset_valid",  int'(sv), 0);
    do_reset();

    // Single word, every configuration.
    send_word(4'b1011);
    wait_idle(100);
    pin("t1_bits_inst0",   int'(cap[0][3:0]), 4'b1011);
    pin("t1_count_inst0",  vcnt[0], 4);
    pin("t1_count_div3",   vcnt[1], 12);
    pin("t1_bits_lsb",     int'(cap[2][3:0]), 4'b1101);
    pin("t1_count_div2",   vcnt[3], 8);

    // LSB-first single word.
    do_reset();
    send_word(4'b0001);
    wait_idle(100);
    pin("t4_bits_lsb",     int'(cap[2][3:0]), 4'b1000);

    // Back-to-back words: contiguous on inst0, 2-cycle gap on inst2.
    do_reset();
    send_word(4'hA);
    send_word(4'h5);
    wait_idle(100);
    pin("t2_bits_inst0",   int'(cap[0][7:0]), 8'hA5);
    pin("t2_count_inst0",  vcnt[0], 8);
    pin("t2_run_inst0",    maxrun[0], 8);
    pin("t4_count_gap",    vcnt[2], 8);
    pin("t4_gap_cycles",   lastgap[2], 2);

    // DIV=3 with a two-cycle pause inside bit 1.
    do_reset();
    send_word(4'b1100);
    for (int k = 0; k < 50; k++) begin
      if (vcnt[1] >= 4) break;
      tick();
    end
    en = 1'b0;
    tick();
    tick();
    en = 1'b1;
    wait_idle(100);
    pin("t3_count_div3",   vcnt[1], 14);
    pin("t3_run_div3",     maxrun[1], 14);
    pin("t3_bits_inst0",   int'(cap[0][3:0]), 4'b1100);

    // Reset in the middle of a frame.
    do_reset();
    send_word(4'b1111);
    for (int k = 0; k < 50; k++) begin
      if (vcnt[0] >= 2) break;
      tick();
    end
    rst_n = 1'b0;
    #1;
    pin("t5_rst_out",      int'(so[0]), 0);
    pin("t5_rst_valid",    int'(sv[0]), 0);
    pin("t5_rst_first",    int'(sf[0]), 0);
    pin("t5_rst_last",     int'(sl[0]), 0);
    pin("t5_rst_busy",     int'(bsy[0]), 0);
    pin("t5_rst_ready",    int'(rdy[0]), 1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    clear_cap();
    for (int k = 0; k < 6; k++) tick();
    pin("t5_no_residual",  vcnt[0], 0);
    send_word(4'b0110);
    wait_idle(100);
    pin("t5_bits_after",   int'(cap[0][3:0]), 4'b0110);
    pin("t5_count_after",  vcnt[0], 4);

    // Offers while not ready must not disturb the held word.
    do_reset();
    send_word(4'h3);
    send_word(4'hC);
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (rdy[0]) break;
      in_data = 4'hC ^ 4'($urandom_range(1, 15));
      tick();
    end
    in_valid = 1'b0;
    wait_idle(100);
    pin("t6_bits_inst0",   int'(cap[0][7:0]), 8'h3C);
    pin("t6_count_inst0",  vcnt[0], 8);

    // Randomised traffic, pauses and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 1) == 1);
      in_data  = 4'($urandom);
      en       = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    en       = 1'b1;
    wait_idle(200);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
